// File: rtl/sopc_run_ctrl_if.sv
// Run-control bus: restart/completion inputs and the reset/status outputs.
// Latency: none, plain bundle of wires.
// Backpressure: none; levels and single-cycle pulses only.
interface sopc_run_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
);
  logic             soft_restart;
  logic             cpu_done;
  logic [N_CH-1:0]  core_rst;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  // Controller side drives resets and status.
  modport master (
    input  soft_restart,
    input  cpu_done,
    output core_rst,
    output running,
    output done,
    output timeout,
    output cycle_cnt
  );

  // SoC / bench side drives restart and completion.
  modport slave (
    output soft_restart,
    output cpu_done,
    input  core_rst,
    input  running,
    input  done,
    input  timeout,
    input  cycle_cnt
  );
endinterface

// File: rtl/sopc_run_ctrl.sv
// Reset sequencer and run watchdog: staggered channel release, bounded run, soft restart.
// Latency: all outputs registered; every input acts on the next rising edge.
// Backpressure: none; cpu_done and soft_restart are sampled each edge, never stalled.
module sopc_run_ctrl #(
  parameter int RST_CYCLES = 10,
  parameter int N_CH       = 2,
  parameter int STAGGER    = 2,
  parameter int RUN_CYCLES = 100,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  sopc_run_ctrl_if.master bus
);

  // Last hold-counter value: the edge on which the final channel releases.
  localparam int HOLD_MAX = RST_CYCLES + (N_CH - 1) * STAGGER;
  localparam int HCNT_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HCNT_W-1:0] HOLD_END = HCNT_W'(HOLD_MAX);

  // Limit compare value is one below the limit so the timeout lands on the
  // same edge cycle_cnt reaches RUN_CYCLES.
  localparam bit               LIM_EN = (RUN_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIM    = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] LIM_M1 = LIM_EN ? CNT_W'(RUN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [HCNT_W-1:0] hcnt_inc;
  logic [N_CH-1:0]   core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign hcnt_inc = hcnt_q + HCNT_W'(1);

  // Next-state logic: soft restart wins over everything, then per-state work.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    core_rst_d = core_rst_q;
    running_d  = running_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;

    if (bus.soft_restart) begin
      // This edge becomes edge 0 of a fresh release sequence.
      state_d    = S_HOLD;
      hcnt_d     = '0;
      core_rst_d = '1;
      running_d  = 1'b0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          hcnt_d = hcnt_inc;
          // Channel i drops once the counter hits its staggered release edge;
          // bits already cleared are never set again while holding.
          for (int i = 0; i < N_CH; i++) begin
            if (hcnt_inc == HCNT_W'(RST_CYCLES + i * STAGGER)) begin
              core_rst_d[i] = 1'b0;
            end
          end
          if (hcnt_inc == HOLD_END) begin
            state_d   = S_RUN;
            running_d = 1'b1;
          end
        end
        S_RUN: begin
          if (bus.cpu_done) begin
            // Completion beats a coincident limit; count freezes.
            state_d    = S_STOP;
            core_rst_d = '1;
            running_d  = 1'b0;
            done_d     = 1'b1;
          end else if (LIM_EN && (cnt_q == LIM_M1)) begin
            state_d    = S_STOP;
            core_rst_d = '1;
            running_d  = 1'b0;
            timeout_d  = 1'b1;
            cnt_d      = LIM;
          end else if (cnt_q != '1) begin
            // Saturating count keeps unlimited runs from wrapping.
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          // Frozen until restart or reset.
        end
        default: begin
          state_d    = S_HOLD;
          hcnt_d     = '0;
          core_rst_d = '1;
          running_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset forces every channel back into reset at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      hcnt_q     <= '0;
      core_rst_q <= '1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: three configurations checked against a scoreboard of expected snapshots.
// Latency: samples on the falling edge after each counted rising edge.
// Backpressure: not applicable; inputs are directed pulses.
module tb_sopc_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  sopc_run_ctrl_if #(.N_CH(2), .CNT_W(32)) if_def ();
  sopc_run_ctrl_if #(.N_CH(3), .CNT_W(32)) if_ns  ();
  sopc_run_ctrl_if #(.N_CH(2), .CNT_W(32)) if_rc5 ();

  sopc_run_ctrl #(.RST_CYCLES(10), .N_CH(2), .STAGGER(2), .RUN_CYCLES(100), .CNT_W(32))
    u_def (.clk(clk), .rst(rst), .bus(if_def));
  sopc_run_ctrl #(.RST_CYCLES(10), .N_CH(3), .STAGGER(0), .RUN_CYCLES(100), .CNT_W(32))
    u_ns  (.clk(clk), .rst(rst), .bus(if_ns));
  sopc_run_ctrl #(.RST_CYCLES(10), .N_CH(2), .STAGGER(2), .RUN_CYCLES(5), .CNT_W(32))
    u_rc5 (.clk(clk), .rst(rst), .bus(if_rc5));

  // Edge number since rst last deasserted (edge 1 = first rising edge with rst low).
  int ecnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Snapshot layout: {core_rst[7:0], running, done, timeout, cycle_cnt[31:0]}.
  logic [42:0] st_def, st_ns, st_rc5;
  assign st_def = {6'b0, if_def.core_rst, if_def.running, if_def.done, if_def.timeout, if_def.cycle_cnt};
  assign st_ns  = {5'b0, if_ns.core_rst,  if_ns.running,  if_ns.done,  if_ns.timeout,  if_ns.cycle_cnt};
  assign st_rc5 = {6'b0, if_rc5.core_rst, if_rc5.running, if_rc5.done, if_rc5.timeout, if_rc5.cycle_cnt};

  function automatic logic [42:0] mk(logic [7:0] cr, logic r, logic d, logic t, logic [31:0] c);
    return {cr, r, d, t, c};
  endfunction

  logic [42:0] exp_q[$];
  string       tag_q[$];
  int total = 0;
  int bad   = 0;

  task automatic push(string tag, logic [42:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk(logic [42:0] obs);
    logic [42:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%h exp=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  // Advance to the falling edge that follows rising edge n, with a cycle budget.
  task automatic wait_edge(int n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (ecnt < n) begin
      total++;
      bad++;
      $error("FAIL wait_edge obs=%0d exp=%0d", ecnt, n);
    end
  endtask

  initial begin
    if_def.soft_restart = 1'b0; if_def.cpu_done = 1'b0;
    if_ns.soft_restart  = 1'b0; if_ns.cpu_done  = 1'b0;
    if_rc5.soft_restart = 1'b0; if_rc5.cpu_done = 1'b0;

    // Reset values while rst is held.
    #100;
    push("rst_def", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    push("rst_ns",  mk(8'h07, 0, 0, 0, 0)); chk(st_ns);
    #95 rst = 1'b0;

    // Staggered release (defaults) and simultaneous release (N_CH=3, STAGGER=0).
    wait_edge(9);
    push("e9_def", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    push("e9_ns",  mk(8'h07, 0, 0, 0, 0)); chk(st_ns);
    wait_edge(10);
    push("e10_def", mk(8'h02, 0, 0, 0, 0)); chk(st_def);
    push("e10_ns",  mk(8'h00, 1, 0, 0, 0)); chk(st_ns);
    wait_edge(11);
    push("e11_def", mk(8'h02, 0, 0, 0, 0)); chk(st_def);
    push("e11_ns",  mk(8'h00, 1, 0, 0, 1)); chk(st_ns);
    wait_edge(12);
    push("e12_def", mk(8'h00, 1, 0, 0, 0)); chk(st_def);
    push("e12_rc5", mk(8'h00, 1, 0, 0, 0)); chk(st_rc5);

    // cpu_done coincides with the limit edge (RUN_CYCLES=5).
    wait_edge(16);
    push("rc5_pre", mk(8'h00, 1, 0, 0, 4)); chk(st_rc5);
    if_rc5.cpu_done = 1'b1;
    wait_edge(17);
    if_rc5.cpu_done = 1'b0;
    push("rc5_tie", mk(8'h03, 0, 1, 0, 4)); chk(st_rc5);
    wait_edge(30);
    push("rc5_hold", mk(8'h03, 0, 1, 0, 4)); chk(st_rc5);

    // soft_restart beats cpu_done in RUN (rc5 restarted at 40, running at 52).
    wait_edge(39);
    if_rc5.soft_restart = 1'b1;
    wait_edge(40);
    if_rc5.soft_restart = 1'b0;
    wait_edge(52);
    push("rc5_rerun", mk(8'h00, 1, 0, 0, 0)); chk(st_rc5);
    wait_edge(54);
    if_rc5.soft_restart = 1'b1; if_rc5.cpu_done = 1'b1;
    wait_edge(55);
    if_rc5.soft_restart = 1'b0; if_rc5.cpu_done = 1'b0;
    push("rc5_prio", mk(8'h03, 0, 0, 0, 0)); chk(st_rc5);

    // Watchdog timeout on the default instance.
    wait_edge(111);
    push("def_e111", mk(8'h00, 1, 0, 0, 99)); chk(st_def);
    wait_edge(112);
    push("def_tmo", mk(8'h03, 0, 0, 1, 100)); chk(st_def);
    wait_edge(119);
    if_def.cpu_done = 1'b1;
    wait_edge(120);
    if_def.cpu_done = 1'b0;
    push("def_stop_ign", mk(8'h03, 0, 0, 1, 100)); chk(st_def);

    // soft_restart from STOP at edge 131; run repeats with a 131-edge offset.
    wait_edge(130);
    if_def.soft_restart = 1'b1;
    wait_edge(131);
    if_def.soft_restart = 1'b0;
    push("sr_clear", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    wait_edge(134);
    if_def.cpu_done = 1'b1;
    wait_edge(135);
    if_def.cpu_done = 1'b0;
    push("hold_ign", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    wait_edge(140);
    push("sr_e9", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    wait_edge(141);
    push("sr_e10", mk(8'h02, 0, 0, 0, 0)); chk(st_def);
    wait_edge(143);
    push("sr_e12", mk(8'h00, 1, 0, 0, 0)); chk(st_def);
    wait_edge(242);
    push("sr_e111", mk(8'h00, 1, 0, 0, 99)); chk(st_def);
    wait_edge(243);
    push("sr_tmo", mk(8'h03, 0, 0, 1, 100)); chk(st_def);

    // cpu_done 37 edges into RUN: restart at 250, running at 262, done at 299.
    wait_edge(249);
    if_def.soft_restart = 1'b1;
    wait_edge(250);
    if_def.soft_restart = 1'b0;
    wait_edge(262);
    push("cd_run", mk(8'h00, 1, 0, 0, 0)); chk(st_def);
    wait_edge(298);
    push("cd_pre", mk(8'h00, 1, 0, 0, 36)); chk(st_def);
    if_def.cpu_done = 1'b1;
    wait_edge(299);
    if_def.cpu_done = 1'b0;
    push("cd_done", mk(8'h03, 0, 1, 0, 36)); chk(st_def);
    for (int k = 1; k <= 50; k++) begin
      wait_edge(299 + k);
      push($sformatf("cd_hold%0d", k), mk(8'h03, 0, 1, 0, 36));
      chk(st_def);
    end

    // Async rst between release edges 11 and 12 of a fresh sequence.
    wait_edge(349);
    if_def.soft_restart = 1'b1;
    wait_edge(350);
    if_def.soft_restart = 1'b0;
    wait_edge(361);
    push("ar_pre", mk(8'h02, 0, 0, 0, 0)); chk(st_def);
    #3 rst = 1'b1;
    #2;
    push("ar_async", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    #40;
    @(negedge clk);
    #5 rst = 1'b0;
    wait_edge(9);
    push("ar_e9", mk(8'h03, 0, 0, 0, 0)); chk(st_def);
    wait_edge(10);
    push("ar_e10", mk(8'h02, 0, 0, 0, 0)); chk(st_def);
    wait_edge(12);
    push("ar_e12", mk(8'h00, 1, 0, 0, 0)); chk(st_def);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
